// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: FIFO-buffered operand issue and result capture around a
// sequential signed shift-add multiplier with a valid/ready result slot.
module mult_issue_ctrl #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N/2-1:0]   in_a,
    input  logic [N/2-1:0]   in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic [N/2-1:0]   mul_inA,
    output logic [N/2-1:0]   mul_inB,
    output logic             mul_init,
    input  logic [N-1:0]     mul_out
);
    localparam int H  = N / 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(H);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state;
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] run_cnt;
    logic          push, pop, done, capture;

    assign in_ready = count != (AW+1)'(DEPTH);
    assign push     = in_valid & in_ready;
    assign pop      = (state == IDLE) & (|count);
    assign done     = (state == RUN) & (run_cnt == CW'(H - 1));
    assign capture  = done & (!res_valid | res_ready);

    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= {in_a, in_b};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            run_cnt   <= '0;
            mul_init  <= 1'b0;
            mul_inA   <= '0;
            mul_inB   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            // a capture on the same edge as a consume keeps the slot full
            res_valid <= capture | (res_valid & !res_ready);
            if (capture) res_data <= mul_out;
            case (state)
                IDLE: if (pop) begin
                    {mul_inA, mul_inB} <= mem[rd_ptr];
                    mul_init <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    mul_init <= 1'b0;
                    run_cnt  <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    if (!done) run_cnt <= run_cnt + CW'(1);
                    if (capture) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: directed checks of mult_issue_ctrl against a behavioural
// sequential multiplier that only shows the true product once it has halted.
module tb_mult_issue_ctrl;
    logic        clock = 0, reset = 1;
    logic        in_valid = 0, in_ready, res_valid, res_ready = 1, mul_init;
    logic [15:0] in_a = 0, in_b = 0, mul_inA, mul_inB;
    logic [31:0] res_data, mul_out;

    int total = 0, bad = 0, cyc = 0, nres = 0, last = 0;
    bit chk_gap = 0, have_last = 0, saw_full = 0, done = 0;
    logic [31:0] expq[$];

    logic [31:0] mprod = 0;
    int          mcnt = 15;

    mult_issue_ctrl #(.N(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .mul_inA(mul_inA), .mul_inB(mul_inB),
        .mul_init(mul_init), .mul_out(mul_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // multiplier stand-in: garbage until its step counter halts at 15
    always @(posedge clock)
        if (mul_init) begin
            mprod <= $signed(mul_inA) * $signed(mul_inB);
            mcnt  <= 0;
        end else if (mcnt < 15) mcnt <= mcnt + 1;
    assign mul_out = (mcnt == 15) ? mprod : ~mprod;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [31:0] gold(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    always @(negedge clock)
        if (!reset && res_valid && res_ready) begin
            if (expq.size() == 0) check("res_extra", 64'(expq.size()), 1);
            else check("res", res_data, expq.pop_front());
            nres++;
            if (chk_gap) begin
                if (have_last) check("gap", 64'(cyc - last), 18);
                last      = cyc;
                have_last = 1;
            end
        end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] e);
        int w = 0;
        in_a = a; in_b = b; in_valid = 1;
        while (!in_ready && w < 300) begin
            saw_full = 1;
            tick();
            w++;
        end
        check("accept", in_ready, 1);
        tick();
        expq.push_back(e);
    endtask

    task automatic wait_drain();
        int w = 0;
        while (expq.size() != 0 && w < 800) begin
            tick();
            w++;
        end
        check("drain", 64'(expq.size()), 0);
        repeat (3) tick();
    endtask

    task automatic measure(output int n, output int inits);
        n = 1;
        inits = 0;
        while (!res_valid && n < 60) begin
            if (mul_init) inits++;
            tick();
            n++;
        end
    endtask

    initial begin
        int n, inits, base;
        logic [31:0] first;
        bit seen, changed;
        #200_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, inits, base;
        logic [31:0] first;
        bit seen, changed;
        logic [15:0] ra, rb;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_mul_init", mul_init, 0);
        check("rst_mul_ops", {mul_inA, mul_inB}, 0);
        reset = 0;
        tick();

        send(16'd3, 16'hFFFE, 32'hFFFF_FFFA);
        in_valid = 0;
        measure(n, inits);
        check("latency", 64'(n), 19);
        check("init_cycles", 64'(inits), 1);
        check("single_data", res_data, 32'hFFFF_FFFA);
        wait_drain();

        send(16'h8000, 16'h8000, 32'h4000_0000);
        send(16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
        send(16'h8000, 16'h7FFF, 32'hC000_8000);
        send(16'h0000, 16'h1234, 32'h0000_0000);
        in_valid = 0;
        wait_drain();

        saw_full = 0; have_last = 0; chk_gap = 1;
        send(16'd1, 16'd1, 32'd1);
        send(16'd2, 16'd3, 32'd6);
        send(16'hFFFF, 16'hFFFF, 32'd1);
        send(16'd100, 16'hFFFC, 32'hFFFF_FE70);
        send(16'h0100, 16'h0100, 32'h0001_0000);
        check("burst_not_full", saw_full, 0);
        send(16'd7, 16'hFFF8, 32'hFFFF_FFC8);
        in_valid = 0;
        check("burst_full", saw_full, 1);
        wait_drain();
        chk_gap = 0;

        res_ready = 0;
        send(16'd10, 16'd10, 32'd100);
        send(16'hFFFE, 16'd5, 32'hFFFF_FFF6);
        send(16'h1000, 16'h0010, 32'h0001_0000);
        in_valid = 0;
        seen = 0; changed = 0; first = 0;
        repeat (60) begin
            tick();
            if (res_valid) begin
                if (!seen) begin first = res_data; seen = 1; end
                else if (res_data !== first) changed = 1;
            end
        end
        check("bp_valid", res_valid, 1);
        check("bp_stable", changed, 0);
        check("bp_data", res_data, 32'd100);
        check("bp_stall_cnt", dut.run_cnt, 15);
        res_ready = 1;
        tick();
        check("bp_swap_valid", res_valid, 1);
        check("bp_swap_data", res_data, 32'hFFFF_FFF6);
        wait_drain();

        send(16'd9, 16'd9, 32'd81);
        in_valid = 0;
        repeat (10) tick();
        check("mid_run_cnt", dut.run_cnt, 8);
        reset = 1;
        #1;
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_init", mul_init, 0);
        check("mid_rst_ready", in_ready, 1);
        expq.delete();
        tick();
        reset = 0;
        tick();
        send(16'd5, 16'd7, 32'd35);
        in_valid = 0;
        measure(n, inits);
        check("post_rst_latency", 64'(n), 19);
        check("post_rst_data", res_data, 32'd35);
        wait_drain();

        base = nres;
        done = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    send(ra, rb, gold(ra, rb));
                    in_valid = 0;
                end
                wait_drain();
                done = 1;
            end
            begin
                while (!done) begin
                    res_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                res_ready = 1;
            end
        join
        check("rand_count", 64'(nres - base), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
